mole_round_scheduler: RTL and testbench
=======================================

# mole_round_scheduler

Round controller for the whack-a-mole game. It clears the 8-slot unique mole selector, requests one unique mole position at a time, and lights that mole for a fixed window. It scores button hits and misses, then ends the round once the selector reports all 8 slots used. It sits between the unique selector and the board I/O (LED drive, debounced buttons).

## Interface
Parameters:
- LIT_CYCLES, 16: cycles a mole stays lit without a hit (≥2)
- GAP_CYCLES, 4: blank cycles between moles (≥1)
- SEL_TIMEOUT, 64: max cycles waiting for selector `done` before error (≥2)

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  begin a round; sampled only in IDLE
- sel_clr  out  1  one-cycle pulse driving the selector's active-high reset
- sel_req  out  1  one-cycle request pulse to the selector
- sel_done  in  1  selector result-valid pulse
- sel_number  in  3  selected mole index, valid with sel_done
- sel_all  in  1  selector reports all 8 slots used
- btn  in  8  debounced, synchronized buttons, one bit per mole
- mole  out  8  one-hot lit mole, 0 when none lit
- score  out  4  hits this round, 0..8
- misses  out  4  misses this round, 0..8
- busy  out  1  high in every state except IDLE
- round_done  out  1  one-cycle pulse at round end
- err  out  1  sticky selector-timeout flag; cleared by next start or reset

## Operation
- States: IDLE, CLEAR, REQ, WAIT_SEL, LIT, GAP, FINISH.
- IDLE, start=1: go to CLEAR. Clear score, misses, err.
- CLEAR: sel_clr=1 for exactly one cycle, then REQ.
- REQ: sel_req=1 for exactly one cycle. Clear the timer. Go to WAIT_SEL.
- WAIT_SEL, sel_done=1:
  - Latch sel_number.
  - Drive mole = 1<<sel_number.
  - Load timer. Go to LIT.
- WAIT_SEL, no sel_done within SEL_TIMEOUT cycles: set err=1, mole=0, go to FINISH.
- LIT, btn[idx]=1: score+1, mole=0, go to GAP.
- LIT, timer expires with no hit: misses+1, mole=0, go to GAP.
- LIT, hit on the same cycle as expiry: counts as a hit only.
- Other btn bits during LIT: behaviour depends on the macro (see Configuration).
- GAP: wait GAP_CYCLES with mole=0. Then, if sel_all=1, go to FINISH; otherwise go to REQ.
- FINISH: round_done=1 for one cycle, then IDLE. score, misses and err hold until the next start.
- score+misses equals the number of moles shown. Each saturates at 8 and never wraps.
- start while busy=1 is ignored.

## Timing
- Reset values (asynchronous, while rst_n=0):
  - state=IDLE
  - mole=0, score=0, misses=0
  - sel_clr=0, sel_req=0
  - busy=0, round_done=0, err=0
- Reset mid-round aborts immediately. The selector shares system reset, so it is cleared too.
- start sampled at edge k: sel_clr high in cycle k+1; sel_req high in cycle k+2.
- sel_done sampled at edge j: mole valid from edge j onward, i.e. visible in cycle j+1.
- With no hit, mole is lit for exactly LIT_CYCLES cycles.
- A hit sampled at edge h clears mole and updates score in the same edge.
- GAP lasts exactly GAP_CYCLES cycles. sel_all is sampled on the last GAP cycle.
- Unhit round minimum length: 8×(2+LIT_CYCLES+GAP_CYCLES) cycles plus CLEAR, FINISH and selector latency.
- All outputs are registered. There is no combinational path from any input to any output.

## Configuration
- WRONG_PRESS_PENALTY_EN defined: in LIT, any btn bit other than btn[idx] with btn[idx]=0 counts a miss (misses+1), clears mole and goes to GAP. If btn[idx]=1 in the same cycle, it is a hit.
- WRONG_PRESS_PENALTY_EN undefined: non-lit button presses are ignored.

## Test plan
- Reset then idle: all outputs 0; start pulse → sel_clr high 1 cycle, then sel_req high 1 cycle, busy=1.
- Full round, no presses, with a behavioural selector (done 3 cycles after req): 8 distinct mole patterns, misses=8, score=0, one round_done pulse, busy=0 after.
- Press the correct button 2 cycles after each mole lights: score=8, misses=0, each mole lit exactly 2 cycles.
- Hit on the last LIT cycle: score+1 and misses unchanged. Selector never asserts done: err=1 after 64 cycles, round_done pulses, mole=0.
- Wrong button press during LIT: with WRONG_PRESS_PENALTY_EN, misses+1 and mole cleared next edge; without it, mole stays lit and counters are unchanged.
- rst_n low mid-LIT, and start asserted while busy: reset returns all outputs to 0 and IDLE; start while busy has no effect on state or counters.

Source files
------------

// File: rtl/mole_round_scheduler.sv
// Whack-a-mole round controller: clears the unique selector, lights one mole at a time, scores hits and misses. Optional macro WRONG_PRESS_PENALTY_EN.
// Latency: start -> sel_clr 1 cycle, sel_req 2 cycles; sel_done -> mole lit next cycle; every output is registered.
// Backpressure: none; sel_done is awaited for at most SEL_TIMEOUT cycles, and start is ignored while busy.
module mole_round_scheduler #(
    parameter int LIT_CYCLES  = 16,
    parameter int GAP_CYCLES  = 4,
    parameter int SEL_TIMEOUT = 64
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic       sel_clr,
    output logic       sel_req,
    input  logic       sel_done,
    input  logic [2:0] sel_number,
    input  logic       sel_all,
    input  logic [7:0] btn,
    output logic [7:0] mole,
    output logic [3:0] score,
    output logic [3:0] misses,
    output logic       busy,
    output logic       round_done,
    output logic       err
);

    localparam int TMAX_LG = (LIT_CYCLES > GAP_CYCLES) ? LIT_CYCLES : GAP_CYCLES;
    localparam int TMAX    = (TMAX_LG > SEL_TIMEOUT) ? TMAX_LG : SEL_TIMEOUT;
    localparam int TW      = (TMAX > 2) ? $clog2(TMAX) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_REQ,
        S_WAIT_SEL,
        S_LIT,
        S_GAP,
        S_FINISH
    } state_t;

    state_t        state, state_n;
    logic [TW-1:0] timer, timer_n;
    logic [2:0]    idx, idx_n;
    logic [7:0]    mole_n;
    logic [3:0]    score_n, misses_n;
    logic          sel_clr_n, sel_req_n, busy_n, round_done_n, err_n;
    logic          hit, wrong;

    // Counters stop at 8 instead of wrapping.
    function automatic logic [3:0] sat_inc(input logic [3:0] v);
        return (v >= 4'd8) ? v : v + 4'd1;
    endfunction

    assign hit = btn[idx];
`ifdef WRONG_PRESS_PENALTY_EN
    assign wrong = |btn;
`else
    assign wrong = 1'b0;
`endif

    always_comb begin
        state_n      = state;
        timer_n      = timer;
        idx_n        = idx;
        mole_n       = mole;
        score_n      = score;
        misses_n     = misses;
        err_n        = err;
        sel_clr_n    = 1'b0;
        sel_req_n    = 1'b0;
        round_done_n = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_n   = S_CLEAR;
                    sel_clr_n = 1'b1;
                    score_n   = 4'd0;
                    misses_n  = 4'd0;
                    err_n     = 1'b0;
                end
            end
            S_CLEAR: begin
                state_n   = S_REQ;
                sel_req_n = 1'b1;
            end
            S_REQ: begin
                timer_n = '0;
                state_n = S_WAIT_SEL;
            end
            S_WAIT_SEL: begin
                if (sel_done) begin
                    idx_n   = sel_number;
                    mole_n  = 8'b1 << sel_number;
                    timer_n = TW'(LIT_CYCLES - 1);
                    state_n = S_LIT;
                end else if (timer == TW'(SEL_TIMEOUT - 1)) begin
                    err_n        = 1'b1;
                    mole_n       = 8'd0;
                    round_done_n = 1'b1;
                    state_n      = S_FINISH;
                end else begin
                    timer_n = timer + 1'b1;
                end
            end
            S_LIT: begin
                // A hit wins over both expiry and a simultaneous wrong press.
                if (hit) begin
                    score_n = sat_inc(score);
                    mole_n  = 8'd0;
                    timer_n = TW'(GAP_CYCLES - 1);
                    state_n = S_GAP;
                end else if (wrong || timer == '0) begin
                    misses_n = sat_inc(misses);
                    mole_n   = 8'd0;
                    timer_n  = TW'(GAP_CYCLES - 1);
                    state_n  = S_GAP;
                end else begin
                    timer_n = timer - 1'b1;
                end
            end
            S_GAP: begin
                if (timer == '0) begin
                    if (sel_all) begin
                        round_done_n = 1'b1;
                        state_n      = S_FINISH;
                    end else begin
                        sel_req_n = 1'b1;
                        state_n   = S_REQ;
                    end
                end else begin
                    timer_n = timer - 1'b1;
                end
            end
            S_FINISH: begin
                state_n = S_IDLE;
            end
            default: begin
                state_n = S_IDLE;
                mole_n  = 8'd0;
            end
        endcase
        busy_n = (state_n != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            timer      <= '0;
            idx        <= 3'd0;
            mole       <= 8'd0;
            score      <= 4'd0;
            misses     <= 4'd0;
            sel_clr    <= 1'b0;
            sel_req    <= 1'b0;
            busy       <= 1'b0;
            round_done <= 1'b0;
            err        <= 1'b0;
        end else begin
            state      <= state_n;
            timer      <= timer_n;
            idx        <= idx_n;
            mole       <= mole_n;
            score      <= score_n;
            misses     <= misses_n;
            sel_clr    <= sel_clr_n;
            sel_req    <= sel_req_n;
            busy       <= busy_n;
            round_done <= round_done_n;
            err        <= err_n;
        end
    end

endmodule

// File: tb/tb_mole_round_scheduler.sv
// Directed bench for mole_round_scheduler with a behavioural unique selector (done 3 cycles after req).
module tb_mole_round_scheduler;

    localparam int LIT = 16;
    localparam int GAP = 4;
    localparam int TMO = 64;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       sel_clr, sel_req;
    logic       sel_done = 1'b0;
    logic [2:0] sel_number = 3'd0;
    logic       sel_all = 1'b0;
    logic [7:0] btn = 8'd0;
    logic [7:0] mole;
    logic [3:0] score, misses;
    logic       busy, round_done, err;

    int vectors = 0;
    int miscompares = 0;

    logic [2:0] order [8] = '{3'd5, 3'd2, 3'd7, 3'd0, 3'd3, 3'd6, 3'd1, 3'd4};
    bit         sel_en = 1'b1;
    int         sel_cnt = 0;
    int         sel_pos = 0;

    mole_round_scheduler #(
        .LIT_CYCLES (LIT),
        .GAP_CYCLES (GAP),
        .SEL_TIMEOUT(TMO)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .sel_clr   (sel_clr),
        .sel_req   (sel_req),
        .sel_done  (sel_done),
        .sel_number(sel_number),
        .sel_all   (sel_all),
        .btn       (btn),
        .mole      (mole),
        .score     (score),
        .misses    (misses),
        .busy      (busy),
        .round_done(round_done),
        .err       (err)
    );

    always #5 clk = ~clk;

    // Behavioural selector: hands out the fixed order, done 3 cycles after each req.
    always @(negedge clk) begin
        sel_done = 1'b0;
        if (!rst_n || sel_clr) begin
            sel_cnt = 0;
            sel_pos = 0;
            sel_all = 1'b0;
        end else begin
            if (sel_cnt > 0) begin
                sel_cnt = sel_cnt - 1;
                if (sel_cnt == 0) begin
                    sel_done   = 1'b1;
                    sel_number = order[sel_pos];
                    sel_pos    = sel_pos + 1;
                    sel_all    = (sel_pos == 8);
                end
            end
            if (sel_req && sel_en) sel_cnt = 3;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, observed timeout, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_mole(output logic [7:0] m);
        int n;
        n = 0;
        while (mole == 8'd0 && n < 200) begin
            step();
            n++;
        end
        m = mole;
        chk("mole_appears", 32'(mole != 8'd0), 32'd1);
    endtask

    task automatic lit_len(input logic [7:0] m, output int n);
        n = 0;
        while (mole == m && n < 100) begin
            n++;
            step();
        end
    endtask

    task automatic wait_done(input string tag, input logic [3:0] exp_score, input logic [3:0] exp_miss);
        int n;
        n = 0;
        while (!round_done && n < 600) begin
            step();
            n++;
        end
        chk({tag, "_round_done"}, 32'(round_done), 32'd1);
        chk({tag, "_score"}, 32'(score), 32'(exp_score));
        chk({tag, "_misses"}, 32'(misses), 32'(exp_miss));
        step();
        chk({tag, "_done_one_cycle"}, 32'(round_done), 32'd0);
        chk({tag, "_busy_after"}, 32'(busy), 32'd0);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    initial begin
        logic [7:0] m;
        int n;

        // Reset state
        step();
        step();
        chk("rst_mole", 32'(mole), 32'd0);
        chk("rst_score", 32'(score), 32'd0);
        chk("rst_misses", 32'(misses), 32'd0);
        chk("rst_ctrl", {27'd0, sel_clr, sel_req, busy, round_done, err}, 32'd0);
        rst_n = 1'b1;
        step();
        chk("idle_ctrl", {27'd0, sel_clr, sel_req, busy, round_done, err}, 32'd0);

        // Round A: no presses, every mole times out
        step();
        pulse_start();
        chk("A_sel_clr", 32'(sel_clr), 32'd1);
        chk("A_busy", 32'(busy), 32'd1);
        chk("A_no_req_yet", 32'(sel_req), 32'd0);
        step();
        chk("A_clr_one_cycle", 32'(sel_clr), 32'd0);
        chk("A_sel_req", 32'(sel_req), 32'd1);
        n = 0;
        while (mole == 8'd0 && n < 50) begin
            step();
            n++;
        end
        chk("A_req_to_mole", 32'(n), 32'd4);
        chk("A_mole0", 32'(mole), 32'(8'b1 << order[0]));
        m = mole;
        lit_len(m, n);
        chk("A_lit_len0", 32'(n), 32'(LIT));
        chk("A_miss0", 32'(misses), 32'd1);
        n = 0;
        while (!sel_req && n < 50) begin
            step();
            n++;
        end
        chk("A_gap_len", 32'(n), 32'(GAP));
        for (int i = 1; i < 8; i++) begin
            wait_mole(m);
            chk("A_mole", 32'(m), 32'(8'b1 << order[i]));
            lit_len(m, n);
            chk("A_lit_len", 32'(n), 32'(LIT));
        end
        wait_done("A", 4'd0, 4'd8);

        // Round B: correct press 2 cycles after each mole lights
        pulse_start();
        chk("B_score_clr", 32'(score), 32'd0);
        chk("B_miss_clr", 32'(misses), 32'd0);
        for (int i = 0; i < 8; i++) begin
            wait_mole(m);
            chk("B_mole", 32'(m), 32'(8'b1 << order[i]));
            step();
            chk("B_still_lit", 32'(mole), 32'(m));
            btn = m;
            step();
            btn = 8'd0;
            chk("B_hit_clears", 32'(mole), 32'd0);
            chk("B_score_step", 32'(score), 32'(i + 1));
        end
        wait_done("B", 4'd8, 4'd0);

        // Round C: hit on last lit cycle, wrong press, start while busy
        pulse_start();
        wait_mole(m);
        repeat (LIT - 1) step();
        chk("C_last_cycle_lit", 32'(mole), 32'(m));
        btn = m;
        step();
        btn = 8'd0;
        chk("C_late_hit_mole", 32'(mole), 32'd0);
        chk("C_late_hit_score", 32'(score), 32'd1);
        chk("C_late_hit_misses", 32'(misses), 32'd0);
        wait_mole(m);
        btn = {m[6:0], m[7]};
        step();
        btn = 8'd0;
`ifdef WRONG_PRESS_PENALTY_EN
        chk("C_wrong_mole", 32'(mole), 32'd0);
        chk("C_wrong_misses", 32'(misses), 32'd1);
`else
        chk("C_wrong_mole", 32'(mole), 32'(m));
        chk("C_wrong_misses", 32'(misses), 32'd0);
`endif
        chk("C_wrong_score", 32'(score), 32'd1);
        n = 0;
        while (mole != 8'd0 && n < 100) begin
            step();
            n++;
        end
        wait_mole(m);
        step();
        pulse_start();
        chk("C_busy_start_clr", 32'(sel_clr), 32'd0);
        chk("C_busy_start_busy", 32'(busy), 32'd1);
        chk("C_busy_start_mole", 32'(mole), 32'(m));
        chk("C_busy_start_score", 32'(score), 32'd1);
        chk("C_busy_start_misses", 32'(misses), 32'd1);
        wait_done("C", 4'd1, 4'd7);

        // Selector timeout
        sel_en = 1'b0;
        pulse_start();
        step();
        chk("T_sel_req", 32'(sel_req), 32'd1);
        repeat (TMO) step();
        chk("T_err_not_early", 32'(err), 32'd0);
        step();
        chk("T_err", 32'(err), 32'd1);
        chk("T_round_done", 32'(round_done), 32'd1);
        chk("T_mole", 32'(mole), 32'd0);
        step();
        chk("T_err_sticky", 32'(err), 32'd1);
        chk("T_idle", {30'd0, busy, round_done}, 32'd0);

        // Next start clears err; then reset mid-LIT
        sel_en = 1'b1;
        pulse_start();
        chk("R_err_clr", 32'(err), 32'd0);
        wait_mole(m);
        btn = m;
        step();
        btn = 8'd0;
        chk("R_score_before", 32'(score), 32'd1);
        wait_mole(m);
        step();
        rst_n = 1'b0;
        #1;
        chk("R_mole", 32'(mole), 32'd0);
        chk("R_score", 32'(score), 32'd0);
        chk("R_misses", 32'(misses), 32'd0);
        chk("R_ctrl", {27'd0, sel_clr, sel_req, busy, round_done, err}, 32'd0);
        step();
        rst_n = 1'b1;
        step();
        step();
        chk("R_stays_idle", {19'd0, mole, sel_clr, sel_req, busy, round_done, err}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
